guess_judge: RTL and testbench
==============================

GUESS_JUDGE -- requirements
Module: guess_judge

Interface
REQ-001 The block SHALL take parameter ROWS, default 4, meaning board rows.
REQ-002 The block SHALL take parameter COLS, default 4, meaning board columns; CELLS = ROWS*COLS and IW = $clog2(CELLS).
REQ-003 The block SHALL take parameter GW, default 4, meaning the width of the wrong-guess counter.
REQ-004 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  is the reset: synchronous, active-low.
REQ-006 Port start  input  1  is a level-sampled round-start request.
REQ-007 Port board  input  CELLS  is the target pattern (bit i set = cell i lit), sampled on start.
REQ-008 Port max_wrong  input  GW  is the allowed wrong guesses, sampled on start.
REQ-009 Port guess_valid  input  1  signals that a guess is offered.
REQ-010 Port guess_idx  input  IW  is the guessed cell index.
REQ-011 Port guess_ready  output  1  is high only in PLAY.
REQ-012 Port remaining  output  GW  is the wrong guesses still allowed.
REQ-013 Port found  output  CELLS  is the mask of correctly guessed cells.
REQ-014 Ports hit, miss, repeat  output  1 each  are single-cycle judgement pulses.
REQ-015 Ports win, lose  output  1 each  are held high in WIN/LOSE respectively.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY, JUDGE, WIN, LOSE.
REQ-017 From IDLE, WIN or LOSE, start=1 SHALL latch board and max_wrong, clear found, set remaining=max_wrong, and enter PLAY; if latched board==0, it SHALL enter WIN instead.
REQ-018 start SHALL be ignored in PLAY and JUDGE.
REQ-019 A guess SHALL be accepted on a cycle with guess_valid && guess_ready; guess_idx SHALL be registered and the FSM SHALL enter JUDGE.
REQ-020 In JUDGE (exactly one cycle after acceptance) exactly one of hit/miss/repeat SHALL pulse, then the FSM SHALL return to PLAY, or move to WIN/LOSE.
REQ-021 Hit: board[idx]=1 and found[idx]=0 -> set found[idx]; if found then equals board, the FSM SHALL enter WIN.
REQ-022 Repeat: found[idx]=1 -> no change to found or remaining.
REQ-023 Miss: board[idx]=0 or idx>=CELLS -> if remaining==0, the FSM SHALL enter LOSE, else decrement remaining; remaining SHALL never wrap below 0.
REQ-024 With max_wrong=0, the first miss SHALL enter LOSE.
REQ-025 found and remaining SHALL hold their values in WIN/LOSE until the next start.
REQ-026 guess_valid SHALL be ignored outside PLAY; a guess is never queued.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, found=0, remaining=0, latched board=0, and all pulses, win, lose and guess_ready to 0, regardless of state, including mid-round.
REQ-028 reset SHALL take priority over start and guess_valid on the same edge.

Structure
REQ-029 The state enum and the ROWS/COLS/GW defaults SHALL live in shared package memmatrix_pkg.
REQ-030 The wrong-guess counter SHALL be the sub-module guess_counter (load, saturating decrement, zero flag); everything else stays in guess_judge.

Verification
REQ-031 V1: ROWS=COLS=4, board=16'h0003, max_wrong=2, start, guesses 0 then 1 -> hit,hit; win=1 two cycles after the second accept; found=16'h0003.
REQ-032 V2: same setup, guesses 5,6,7 -> miss x3; remaining 2->1->0; lose=1 after the third JUDGE.
REQ-033 V3: guess 0 twice -> hit, then repeat; remaining unchanged at 2.
REQ-034 V4: board=0, start -> WIN on the next cycle, with no guesses accepted.
REQ-035 V5: reset=0 during JUDGE -> next cycle IDLE with all outputs 0; guess_ready=0 and start re-arms.
REQ-036 V6: ROWS=3, COLS=3, guess_idx=12 -> miss, and remaining decrements.

Source files
------------

// File: rtl/memmatrix_pkg.sv
// Shared types and default geometry for the memory-matrix guessing game.
package memmatrix_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_GW   = 4;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    JUDGE,
    WIN,
    LOSE
  } state_e;

endpackage

// File: rtl/guess_counter.sv
// Wrong-guess budget: loadable, saturating down-counter with a zero flag.
module guess_counter #(
  parameter int GW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [GW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [GW-1:0] count_o,
  output logic          zero_o
);

  logic [GW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/guess_judge.sv
// Round controller: latches a target board, accepts one guess at a time and
// judges it a cycle later as hit, miss or repeat.
module guess_judge
  import memmatrix_pkg::*;
#(
  parameter  int ROWS  = DEF_ROWS,
  parameter  int COLS  = DEF_COLS,
  parameter  int GW    = DEF_GW,
  localparam int CELLS = ROWS * COLS,
  localparam int IW    = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CELLS-1:0] board,
  input  logic [GW-1:0]    max_wrong,
  input  logic             guess_valid,
  input  logic [IW-1:0]    guess_idx,
  output logic             guess_ready,
  output logic [GW-1:0]    remaining,
  output logic [CELLS-1:0] found,
  output logic             hit,
  output logic             miss,
  output logic             repeat_o,
  output logic             win,
  output logic             lose
);

  state_e           state_q, state_d;
  logic [CELLS-1:0] board_q, board_d;
  logic [CELLS-1:0] found_q, found_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             in_range;
  logic [CELLS-1:0] idx_mask;

  // Indices beyond the board (non power-of-two geometries) always count as misses.
  assign in_range = ({1'b0, idx_q} < (IW + 1)'(CELLS));
  assign idx_mask = CELLS'(1) << idx_q;

  guess_counter #(.GW(GW)) u_guess_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (max_wrong),
    .dec_i      (cnt_dec),
    .count_o    (remaining),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    found_d  = found_q;
    idx_d    = idx_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    hit      = 1'b0;
    miss     = 1'b0;
    repeat_o = 1'b0;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          board_d  = board;
          found_d  = '0;
          cnt_load = 1'b1;
          state_d  = (board == '0) ? WIN : PLAY;
        end
      end
      PLAY: begin
        if (guess_valid) begin
          idx_d   = guess_idx;
          state_d = JUDGE;
        end
      end
      JUDGE: begin
        if (in_range && found_q[idx_q]) begin
          repeat_o = 1'b1;
          state_d  = PLAY;
        end else if (in_range && board_q[idx_q]) begin
          hit     = 1'b1;
          found_d = found_q | idx_mask;
          state_d = (found_d == board_q) ? WIN : PLAY;
        end else begin
          miss = 1'b1;
          if (cnt_zero) begin
            state_d = LOSE;
          end else begin
            cnt_dec = 1'b1;
            state_d = PLAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      board_q <= '0;
      found_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      found_q <= found_d;
      idx_q   <= idx_d;
    end
  end

  assign guess_ready = (state_q == PLAY);
  assign win         = (state_q == WIN);
  assign lose        = (state_q == LOSE);
  assign found       = found_q;

endmodule

// File: tb/tb_guess_judge.sv
// Scoreboard bench for guess_judge: directed rounds on a 4x4 board plus a 3x3 instance.
module tb_guess_judge;

  localparam logic [2:0] K_HIT  = 3'b100;
  localparam logic [2:0] K_MISS = 3'b010;
  localparam logic [2:0] K_REP  = 3'b001;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] board = '0;
  logic [3:0]  max_wrong = '0;
  logic        guess_valid = 1'b0;
  logic [3:0]  guess_idx = '0;
  logic        guess_ready, hit, miss, repeat_o, win, lose;
  logic [3:0]  remaining;
  logic [15:0] found;

  logic        start3 = 1'b0;
  logic [8:0]  board3 = '0;
  logic [3:0]  max_wrong3 = '0;
  logic        guess_valid3 = 1'b0;
  logic [3:0]  guess_idx3 = '0;
  logic        guess_ready3, hit3, miss3, repeat3, win3, lose3;
  logic [3:0]  remaining3;
  logic [8:0]  found3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  guess_judge dut (
    .clk(clk), .reset(reset), .start(start), .board(board), .max_wrong(max_wrong),
    .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_ready(guess_ready),
    .remaining(remaining), .found(found), .hit(hit), .miss(miss), .repeat_o(repeat_o),
    .win(win), .lose(lose)
  );

  guess_judge #(.ROWS(3), .COLS(3), .GW(4)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .board(board3), .max_wrong(max_wrong3),
    .guess_valid(guess_valid3), .guess_idx(guess_idx3), .guess_ready(guess_ready3),
    .remaining(remaining3), .found(found3), .hit(hit3), .miss(miss3), .repeat_o(repeat3),
    .win(win3), .lose(lose3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every judgement pulse must match the oldest expected judgement.
  always @(negedge clk) begin
    if (hit || miss || repeat_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, hit, miss, repeat_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("judge_kind", {29'd0, hit, miss, repeat_o}, {29'd0, e.kind});
        check("judge_remaining", {28'd0, remaining}, {28'd0, e.rem});
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [3:0] mw);
    @(posedge clk); #1;
    start = 1'b1; board = b; max_wrong = mw;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_guess(input logic [3:0] idx, input logic [2:0] kind, input logic [3:0] rem);
    int n;
    n = 0;
    while (!guess_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("guess_ready_before_guess", {31'd0, guess_ready}, 32'd1);
    exp_q.push_back('{kind: kind, rem: rem});
    guess_valid = 1'b1; guess_idx = idx;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, guess_ready}, 32'd0);
    check("rst_win_lose", {30'd0, win, lose}, 32'd0);
    check("rst_remaining", {28'd0, remaining}, 32'd0);
    check("rst_found", {16'd0, found}, 32'd0);
    check("rst_pulses", {29'd0, hit, miss, repeat_o}, 32'd0);
    reset = 1'b1;

    // V1: two hits complete the board
    do_start(16'h0003, 4'd2);
    check("v1_ready", {31'd0, guess_ready}, 32'd1);
    check("v1_remaining_loaded", {28'd0, remaining}, 32'd2);
    do_guess(4'd0, K_HIT, 4'd2);
    check("v1_found_after_first", {16'd0, found}, 32'h0001);
    do_guess(4'd1, K_HIT, 4'd2);
    check("v1_win", {31'd0, win}, 32'd1);
    check("v1_found", {16'd0, found}, 32'h0003);
    check("v1_ready_low_in_win", {31'd0, guess_ready}, 32'd0);

    // V3: hit then repeat leaves remaining alone
    do_start(16'h0003, 4'd2);
    do_guess(4'd0, K_HIT, 4'd2);
    do_guess(4'd0, K_REP, 4'd2);
    check("v3_remaining", {28'd0, remaining}, 32'd2);
    check("v3_found", {16'd0, found}, 32'h0001);

    // start during PLAY must be ignored even with an empty board
    do_start(16'h0000, 4'd9);
    check("ign_start_ready", {31'd0, guess_ready}, 32'd1);
    check("ign_start_win", {31'd0, win}, 32'd0);
    check("ign_start_remaining", {28'd0, remaining}, 32'd2);

    // V2: three misses, counter saturates then LOSE
    do_guess(4'd5, K_MISS, 4'd2);
    check("v2_rem_after_1", {28'd0, remaining}, 32'd1);
    do_guess(4'd6, K_MISS, 4'd1);
    check("v2_rem_after_2", {28'd0, remaining}, 32'd0);
    check("v2_not_lost_yet", {31'd0, lose}, 32'd0);
    do_guess(4'd7, K_MISS, 4'd0);
    check("v2_lose", {31'd0, lose}, 32'd1);
    check("v2_rem_held", {28'd0, remaining}, 32'd0);
    check("v2_found_held", {16'd0, found}, 32'h0001);

    // Guesses offered in LOSE are dropped
    guess_valid = 1'b1; guess_idx = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    guess_valid = 1'b0;
    check("lose_ignores_guess_found", {16'd0, found}, 32'h0001);
    check("lose_held", {31'd0, lose}, 32'd1);

    // V4: empty board wins immediately
    do_start(16'h0000, 4'd3);
    check("v4_win", {31'd0, win}, 32'd1);
    check("v4_ready", {31'd0, guess_ready}, 32'd0);
    check("v4_remaining", {28'd0, remaining}, 32'd3);

    // max_wrong=0: first miss loses
    do_start(16'h8000, 4'd0);
    do_guess(4'd3, K_MISS, 4'd0);
    check("mw0_lose", {31'd0, lose}, 32'd1);

    // V5: reset while in JUDGE
    do_start(16'h0003, 4'd2);
    exp_q.push_back('{kind: K_HIT, rem: 4'd2});
    guess_valid = 1'b1; guess_idx = 4'd0;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    reset = 1'b0;
    start = 1'b1; board = 16'h0003; max_wrong = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("v5_ready", {31'd0, guess_ready}, 32'd0);
    check("v5_remaining", {28'd0, remaining}, 32'd0);
    check("v5_found", {16'd0, found}, 32'd0);
    check("v5_flags", {27'd0, hit, miss, repeat_o, win, lose}, 32'd0);
    reset = 1'b1;
    do_start(16'h0003, 4'd2);
    check("v5_rearm_ready", {31'd0, guess_ready}, 32'd1);
    check("v5_rearm_remaining", {28'd0, remaining}, 32'd2);

    // V6: 3x3 board, index 12 is off the board
    @(posedge clk); #1;
    start3 = 1'b1; board3 = 9'h001; max_wrong3 = 4'd2;
    @(posedge clk); #1;
    start3 = 1'b0;
    guess_valid3 = 1'b1; guess_idx3 = 4'd12;
    @(posedge clk); #1;
    guess_valid3 = 1'b0;
    check("v6_miss_pulse", {29'd0, hit3, miss3, repeat3}, {29'd0, K_MISS});
    @(posedge clk); #1;
    check("v6_remaining", {28'd0, remaining3}, 32'd1);
    check("v6_ready", {31'd0, guess_ready3}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
